// File: rtl/fairy_div_pkg.sv
// rtl/fairy_div_pkg.sv - shared encodings for the HI/LO divide issue/retire stage
// Contents: datapath width default, op_i encodings, FSM state constants.
package fairy_div_pkg;

  localparam int W_DEF = 32;
  localparam int OP_W_DEF = 2;

  // op_i encodings presented by EX
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  // Controller states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - conditional two's-complement negate (magnitude in, signed out and back)
// Ports:
//   val_i  in  W  value to pass through or negate
//   neg_i  in  1  negate when high
//   res_o  out W  val_i, or -val_i modulo 2^W
module div_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  // Modulo 2^W negation: the most negative value maps onto itself, which
  // is exactly its unsigned magnitude.
  assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/hilo_div_ctrl.sv
// rtl/hilo_div_ctrl.sv - HI/LO owner: issues DIV/DIVU to the unsigned divider, retires sign-corrected results
// Optional feature macro: DIV_ZERO_BYPASS_EN (zero divisor short-circuits the divider).
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   op_valid_i, op_i, rs_i, rt_i    HI/LO-class op from EX (DIV, DIVU, MTHI, MTLO)
//   flush_i                         drop the presented op / abandon an in-flight divide
//   stall_o                         hold EX and earlier stages
//   hi_o, lo_o                      architectural HI (remainder) and LO (quotient)
//   div_ready_o, div_dividend_o,
//   div_divisor_o                   request and unsigned operands to the divider
//   div_valid_i, div_quotient_i,
//   div_remainder_i                 divider result pulse and unsigned results
module hilo_div_ctrl
  import fairy_div_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int OP_W = OP_W_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            op_valid_i,
  input  logic [OP_W-1:0] op_i,
  input  logic [W-1:0]    rs_i,
  input  logic [W-1:0]    rt_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic [W-1:0]    hi_o,
  output logic [W-1:0]    lo_o,
  output logic            div_ready_o,
  output logic [W-1:0]    div_dividend_o,
  output logic [W-1:0]    div_divisor_o,
  input  logic            div_valid_i,
  input  logic [W-1:0]    div_quotient_i,
  input  logic [W-1:0]    div_remainder_i
);

  logic [1:0]   state;
  logic [W-1:0] dividend_q;
  logic [W-1:0] divisor_q;
  logic         neg_q;
  logic         neg_r;

  logic         is_div;
  logic         is_signed;
  logic         rs_neg;
  logic         rt_neg;
  logic         zero_byp;
  logic         in_idle;
  logic         accept_div;
  logic         accept_zero;
  logic         accept_mt;
  logic [W-1:0] rs_mag;
  logic [W-1:0] rt_mag;
  logic [W-1:0] quot_fixed;
  logic [W-1:0] rem_fixed;

  assign is_div    = (op_i == OP_W'(OP_DIV)) || (op_i == OP_W'(OP_DIVU));
  assign is_signed = (op_i == OP_W'(OP_DIV));
  assign rs_neg    = is_signed & rs_i[W-1];
  assign rt_neg    = is_signed & rt_i[W-1];

`ifdef DIV_ZERO_BYPASS_EN
  assign zero_byp = (rt_i == '0);
`else
  assign zero_byp = 1'b0;
`endif

  // Ops are only taken in IDLE; anything presented while busy is held
  // upstream by stall_o and re-presented later.
  assign in_idle     = (state == ST_IDLE);
  assign accept_div  = in_idle & op_valid_i & ~flush_i & is_div & ~zero_byp;
  assign accept_zero = in_idle & op_valid_i & ~flush_i & is_div & zero_byp;
  assign accept_mt   = in_idle & op_valid_i & ~flush_i & ~is_div;

  div_sign_fix #(.W(W)) u_rs_mag (.val_i(rs_i),            .neg_i(rs_neg), .res_o(rs_mag));
  div_sign_fix #(.W(W)) u_rt_mag (.val_i(rt_i),            .neg_i(rt_neg), .res_o(rt_mag));
  div_sign_fix #(.W(W)) u_q_fix  (.val_i(div_quotient_i),  .neg_i(neg_q),  .res_o(quot_fixed));
  div_sign_fix #(.W(W)) u_r_fix  (.val_i(div_remainder_i), .neg_i(neg_r),  .res_o(rem_fixed));

  // Stall is raised combinationally in the accept cycle so EX holds the
  // instruction behind the divide immediately.
  assign stall_o        = ~in_idle | accept_div;
  // DRAIN keeps the request up so the divider finishes its current job.
  assign div_ready_o    = ~in_idle;
  assign div_dividend_o = dividend_q;
  assign div_divisor_o  = divisor_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      hi_o       <= '0;
      lo_o       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_div) begin
            dividend_q <= rs_mag;
            divisor_q  <= rt_mag;
            neg_q      <= rs_neg ^ rt_neg;
            neg_r      <= rs_neg;
            state      <= ST_BUSY;
          end else if (accept_zero) begin
            lo_o <= '1;
            hi_o <= rs_i;
          end else if (accept_mt) begin
            if (op_i == OP_W'(OP_MTHI)) begin
              hi_o <= rs_i;
            end else begin
              lo_o <= rs_i;
            end
          end
        end
        ST_BUSY: begin
          if (div_valid_i) begin
            // A flush landing on the result cycle discards it.
            if (!flush_i) begin
              lo_o <= quot_fixed;
              hi_o <= rem_fixed;
            end
            state <= ST_IDLE;
          end else if (flush_i) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (div_valid_i) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb/tb_hilo_div_ctrl.sv - randomized self-checking bench for hilo_div_ctrl with a behavioural divider
module tb_hilo_div_ctrl;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] MTHI = 2'b10;
  localparam logic [1:0] MTLO = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        op_valid_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] rs_i = '0;
  logic [31:0] rt_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div_ready_o;
  logic [31:0] div_dividend_o;
  logic [31:0] div_divisor_o;
  logic        div_valid_i = 1'b0;
  logic [31:0] div_quotient_i = '0;
  logic [31:0] div_remainder_i = '0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  always #5 clk = ~clk;

  hilo_div_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .op_valid_i(op_valid_i), .op_i(op_i), .rs_i(rs_i), .rt_i(rt_i),
    .flush_i(flush_i), .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o),
    .div_ready_o(div_ready_o), .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
    .div_valid_i(div_valid_i), .div_quotient_i(div_quotient_i), .div_remainder_i(div_remainder_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural result of a divide, from signed/unsigned arithmetic.
  // Zero divisor: the bench divider returns all-ones / dividend magnitude,
  // which after sign correction gives the values below.
  task automatic ref_div(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         output logic [31:0] lo, output logic [31:0] hi);
    longint a, b, q, r;
    if (rt == 0) begin
      lo = (op == DIV && rs[31]) ? 32'd1 : 32'hFFFF_FFFF;
      hi = rs;
    end else if (op == DIVU) begin
      lo = rs / rt;
      hi = rs % rt;
    end else begin
      a = longint'($signed(rs));
      b = longint'($signed(rt));
      q = a / b;
      r = a % b;
      lo = q[31:0];
      hi = r[31:0];
    end
  endtask

  function automatic logic [31:0] mag(input logic [1:0] op, input logic [31:0] v);
    longint a;
    if (op == DIVU) return v;
    a = longint'($signed(v));
    if (a < 0) a = -a;
    return a[31:0];
  endfunction

  // mode 0: normal completion, 1: flush while busy (drain), 2: flush with result
  task automatic run_div(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt, input int mode);
    logic [31:0] exp_lo, exp_hi, dm, vm, qm, rm;
    int lat;
    ref_div(op, rs, rt, exp_lo, exp_hi);
    dm = mag(op, rs);
    vm = mag(op, rt);
    if (vm == 0) begin
      qm = 32'hFFFF_FFFF;
      rm = dm;
    end else begin
      qm = dm / vm;
      rm = dm % vm;
    end
    @(negedge clk);
    op_valid_i = 1'b1; op_i = op; rs_i = rs; rt_i = rt;
    #1;
`ifdef DIV_ZERO_BYPASS_EN
    if (rt == 0) begin
      check("byp_stall", {31'd0, stall_o}, 32'd0);
      @(negedge clk);
      op_valid_i = 1'b0;
      model_lo = 32'hFFFF_FFFF;
      model_hi = rs;
      check("byp_ready", {31'd0, div_ready_o}, 32'd0);
      check("byp_lo", lo_o, model_lo);
      check("byp_hi", hi_o, model_hi);
      return;
    end
`endif
    check("acc_stall", {31'd0, stall_o}, 32'd1);
    @(negedge clk);
    op_valid_i = 1'b0; rs_i = $urandom; rt_i = $urandom;
    check("busy_ready", {31'd0, div_ready_o}, 32'd1);
    check("dividend", div_dividend_o, dm);
    check("divisor", div_divisor_o, vm);
    lat = $urandom_range(0, 4);
    repeat (lat) begin
      // ops presented while busy must be ignored
      op_valid_i = 1'($urandom_range(0, 1));
      op_i = 2'($urandom_range(2, 3));
      @(negedge clk);
      check("busy_stall", {31'd0, stall_o}, 32'd1);
    end
    op_valid_i = 1'b0;
    if (mode == 1) begin
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check("drain_ready", {31'd0, div_ready_o}, 32'd1);
      check("drain_dividend", div_dividend_o, dm);
    end
    div_valid_i = 1'b1; div_quotient_i = qm; div_remainder_i = rm;
    if (mode == 2) flush_i = 1'b1;
    #1;
    check("valid_stall", {31'd0, stall_o}, 32'd1);
    @(negedge clk);
    div_valid_i = 1'b0; flush_i = 1'b0;
    div_quotient_i = $urandom; div_remainder_i = $urandom;
    if (mode == 0) begin
      model_lo = exp_lo;
      model_hi = exp_hi;
    end
    check("done_stall", {31'd0, stall_o}, 32'd0);
    check("done_ready", {31'd0, div_ready_o}, 32'd0);
    check("lo", lo_o, model_lo);
    check("hi", hi_o, model_hi);
  endtask

  task automatic run_mt(input logic [1:0] op, input logic [31:0] v, input logic fl);
    @(negedge clk);
    op_valid_i = 1'b1; op_i = op; rs_i = v; flush_i = fl;
    #1;
    check("mt_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    op_valid_i = 1'b0; flush_i = 1'b0;
    if (!fl) begin
      if (op == MTHI) model_hi = v; else model_lo = v;
    end
    check("mt_hi", hi_o, model_hi);
    check("mt_lo", lo_o, model_lo);
  endtask

  initial begin
    logic [1:0] op;
    logic [31:0] rs, rt;
    int sel;
    repeat (2) @(negedge clk);
    check("rst_hi", hi_o, 32'd0);
    check("rst_lo", lo_o, 32'd0);
    check("rst_ready", {31'd0, div_ready_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    reset_n = 1'b1;

    run_div(DIVU, 32'd100, 32'd7, 0);
    run_div(DIV, 32'hFFFF_FFF9, 32'd2, 0);
    run_div(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_mt(MTHI, 32'h1234, 1'b0);
    run_mt(MTLO, 32'h5678, 1'b0);
    run_mt(MTHI, 32'hDEAD, 1'b1);
    run_div(DIVU, 32'd9, 32'd4, 1);
    run_div(DIV, 32'd50, 32'hFFFF_FFFB, 2);
    run_div(DIV, 32'd5, 32'd0, 0);

    // flushed divide is dropped: no stall, no request
    @(negedge clk);
    op_valid_i = 1'b1; op_i = DIV; rs_i = 32'd77; rt_i = 32'd3; flush_i = 1'b1;
    #1;
    check("flush_drop_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    op_valid_i = 1'b0; flush_i = 1'b0;
    check("flush_drop_ready", {31'd0, div_ready_o}, 32'd0);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2) begin
        run_mt(sel == 0 ? MTHI : MTLO, $urandom, 1'($urandom_range(0, 4) == 0));
      end else begin
        op = 2'($urandom_range(0, 1));
        rs = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
        case ($urandom_range(0, 3))
          0: rt = 32'($urandom_range(0, 3));
          1: rt = 32'hFFFF_FFFF;
          default: rt = $urandom;
        endcase
        run_div(op, rs, rt, ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0);
      end
    end

    // reset while busy aborts the divide and clears HI/LO
    run_mt(MTHI, 32'hAAAA_5555, 1'b0);
    @(negedge clk);
    op_valid_i = 1'b1; op_i = DIVU; rs_i = 32'd9; rt_i = 32'd4;
    @(negedge clk);
    op_valid_i = 1'b0;
    check("pre_rst_ready", {31'd0, div_ready_o}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    model_hi = '0;
    model_lo = '0;
    check("mid_rst_hi", hi_o, model_hi);
    check("mid_rst_lo", lo_o, model_lo);
    check("mid_rst_ready", {31'd0, div_ready_o}, 32'd0);
    check("mid_rst_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_div(DIVU, 32'd100, 32'd7, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
